wb_port_arbiter: RTL and testbench

//  Shares the single register-file write port between the in-order pipeline writeback and a long-latency unit (mul/div).

---
 rtl/wb_arb_pkg.sv | 13 +
 rtl/wb_arb_fifo.sv | 80 ++++++++
 rtl/wb_port_arbiter.sv | 130 +++++++++++++
 tb/tb_wb_port_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types for the writeback-port arbiter: datapath widths and the queued
// long-latency-unit result entry.
package wb_arb_pkg;

    localparam int XLEN   = 64;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wb_arb_fifo.sv
// DEPTH-entry strict FIFO of long-latency-unit results. Exposes occupancy, the
// head entry, and a per-slot destination match used for the pending-write lookup.
module wb_arb_fifo
    import wb_arb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [REG_AW-1:0] push_rd,
    input  logic [XLEN-1:0]   push_data,
    input  logic [REG_AW-1:0] query_rd,
    output logic [REG_AW-1:0] head_rd,
    output logic [XLEN-1:0]   head_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic [DEPTH-1:0]  match_vec
);

    wb_entry_t        mem_q [DEPTH];
    wb_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        // NOTE: every signal gets a default before any condition, so no path can infer a latch.
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{rd: push_rd, data: push_data};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: storage is left unreset; validity comes only from the pointers and count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_rd   = mem_q[rd_ptr_q].rd;
    assign head_data = mem_q[rd_ptr_q].data;
    assign count     = count_q;
    assign full      = (count_q == CNT_W'(DEPTH));

    // A slot is live when its distance from the head is below the occupancy.
    for (genvar i = 0; i < DEPTH; i++) begin : g_match
        logic [PTR_W-1:0] age;
        assign age          = PTR_W'(i) - rd_ptr_q;
        assign match_vec[i] = (CNT_W'(age) < count_q) && (mem_q[i].rd == query_rd);
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between pipeline writeback (always wins) and
// queued long-latency results. Optional WB_ARB_BYPASS_EN sends an LU result straight through when idle.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              lu_valid,
    output logic              lu_ready,
    input  logic [REG_AW-1:0] lu_rd,
    input  logic [XLEN-1:0]   lu_data,
    input  logic [REG_AW-1:0] query_rd,
    output logic              pend_hit,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              stall_req
);

    localparam int CNT_W    = $clog2(DEPTH) + 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [REG_AW-1:0] head_rd;
    logic [XLEN-1:0]   head_data;
    logic [DEPTH-1:0]  match_vec;

    logic slot_busy, lu_accept, bypass, pop, push;

    logic                rf_we_q, rf_we_d;
    logic [REG_AW-1:0]   rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]     rf_wdata_q, rf_wdata_d;
    logic                stall_req_q, stall_req_d;
    logic [STARVE_W-1:0] starve_q, starve_d;

    wb_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .push_rd   (lu_rd),
        .push_data (lu_data),
        .query_rd  (query_rd),
        .head_rd   (head_rd),
        .head_data (head_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .match_vec (match_vec)
    );

    assign fifo_empty = (fifo_count == '0);
    assign slot_busy  = wb_reg_write && (wb_rd != '0);
    assign lu_ready   = !fifo_full;
    assign lu_accept  = lu_valid && lu_ready;
    assign pop        = !slot_busy && !fifo_empty;

`ifdef WB_ARB_BYPASS_EN
    assign bypass = fifo_empty && !slot_busy && lu_accept && (lu_rd != '0);
`else
    assign bypass = 1'b0;
`endif

    // Results for x0 complete the handshake but are dropped here.
    assign push     = lu_accept && (lu_rd != '0) && !bypass;
    assign pend_hit = (query_rd != '0) && (|match_vec);

    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (slot_busy) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = wb_rd;
            rf_wdata_d = wb_data;
        end else if (pop) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = head_rd;
            rf_wdata_d = head_data;
        end else if (bypass) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = lu_rd;
            rf_wdata_d = lu_data;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (fifo_empty || pop) begin
            starve_d = '0;
        end else if (starve_q != STARVE_W'(STARVE_LIMIT)) begin
            starve_d = starve_q + STARVE_W'(1);
        end
        stall_req_d = stall_req_q;
        if (pop) begin
            stall_req_d = 1'b0;
        end else if (starve_q == STARVE_W'(STARVE_LIMIT)) begin
            stall_req_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            stall_req_q <= 1'b0;
            starve_q    <= '0;
        end else begin
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            stall_req_q <= stall_req_d;
            starve_q    <= starve_d;
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign stall_req = stall_req_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios then random traffic,
// all compared against a queue-based reference model of the arbitration rules.
module tb_wb_port_arbiter;
    import wb_arb_pkg::*;

    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wb_reg_write = 1'b0;
    logic [REG_AW-1:0] wb_rd = '0;
    logic [XLEN-1:0]   wb_data = '0;
    logic              lu_valid = 1'b0;
    logic              lu_ready;
    logic [REG_AW-1:0] lu_rd = '0;
    logic [XLEN-1:0]   lu_data = '0;
    logic [REG_AW-1:0] query_rd = '0;
    logic              pend_hit;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [XLEN-1:0]   rf_wdata;
    logic              stall_req;

    always #5 clk = ~clk;

    wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wb_reg_write (wb_reg_write),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .lu_valid     (lu_valid),
        .lu_ready     (lu_ready),
        .lu_rd        (lu_rd),
        .lu_data      (lu_data),
        .query_rd     (query_rd),
        .pend_hit     (pend_hit),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .stall_req    (stall_req)
    );

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    // Reference model: pending LU results in arrival order plus expected port state.
    wb_entry_t         q[$];
    logic              exp_we;
    logic [REG_AW-1:0] exp_addr;
    logic [XLEN-1:0]   exp_data;
    logic              exp_stall;
    int                waited;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_hit(input logic [REG_AW-1:0] r);
        if (r == '0) return 1'b0;
        foreach (q[i]) if (q[i].rd == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        q.delete();
        exp_we    = 1'b0;
        exp_addr  = '0;
        exp_data  = '0;
        exp_stall = 1'b0;
        waited    = 0;
    endtask

    // One clock of traffic: drive, check combinational outputs, advance model, check registers.
    task automatic cyc(input logic wr, input logic [REG_AW-1:0] wrd, input logic [XLEN-1:0] wd,
                       input logic lv, input logic [REG_AW-1:0] lrd, input logic [XLEN-1:0] ld,
                       input logic [REG_AW-1:0] qrd);
        logic      busy, acc, drain, byp, had_work;
        wb_entry_t e;
        wb_reg_write = wr;
        wb_rd        = wrd;
        wb_data      = wd;
        lu_valid     = lv;
        lu_rd        = lrd;
        lu_data      = ld;
        query_rd     = qrd;
        #1;
        chk("lu_ready", lu_ready, q.size() < DEPTH);
        chk("pend_hit", pend_hit, model_hit(qrd));
        busy     = wr && (wrd != '0);
        acc      = lv && (q.size() < DEPTH);
        drain    = !busy && (q.size() > 0);
        had_work = q.size() > 0;
        byp      = 1'b0;
`ifdef WB_ARB_BYPASS_EN
        byp = (q.size() == 0) && !busy && acc && (lrd != '0);
`endif
        exp_we = 1'b1;
        if (busy) begin
            exp_addr = wrd;
            exp_data = wd;
        end else if (drain) begin
            e        = q.pop_front();
            exp_addr = e.rd;
            exp_data = e.data;
        end else if (byp) begin
            exp_addr = lrd;
            exp_data = ld;
        end else begin
            exp_we = 1'b0;
        end
        if (drain) exp_stall = 1'b0;
        else if (waited == STARVE_LIMIT) exp_stall = 1'b1;
        if (!had_work || drain) waited = 0;
        else if (waited < STARVE_LIMIT) waited++;
        if (acc && (lrd != '0) && !byp) q.push_back('{rd: lrd, data: ld});
        @(posedge clk);
        #1;
        chk("rf_we", rf_we, exp_we);
        chk("rf_waddr", rf_waddr, exp_addr);
        chk("rf_wdata", rf_wdata, exp_data);
        chk("stall_req", stall_req, exp_stall);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, '0, '0, '0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rf_we", rf_we, 1'b0);
        chk("reset_stall", stall_req, 1'b0);
        chk("reset_lu_ready", lu_ready, 1'b1);
        chk("reset_pend_hit", pend_hit, 1'b0);
        rst_n = 1'b1;
        idle(1);

        // Priority: pipeline write first, LU result in the next free slot.
        cyc(1'b1, 5'd5, 64'hAA, 1'b1, 5'd7, 64'hBB, 5'd0);
        chk("prio_x5_addr", rf_waddr, 64'd5);
        chk("prio_x5_data", rf_wdata, 64'hAA);
        cyc(1'b0, '0, '0, 1'b0, '0, '0, 5'd7);
        chk("prio_x7_addr", rf_waddr, 64'd7);
        chk("prio_x7_data", rf_wdata, 64'hBB);
        idle(1);

        // Full: four pushes under continuous pipeline writes, fifth held off.
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 5'(1 + i), 64'(100 + i), 1'b1, 5'(10 + i), 64'(200 + i), 5'd12);
        cyc(1'b1, 5'd1, 64'h11, 1'b1, 5'd14, 64'h204, 5'd14);
        chk("full_lu_ready", lu_ready, 1'b0);
        cyc(1'b0, '0, '0, 1'b1, 5'd14, 64'h204, 5'd10);
        chk("full_drain_head", rf_waddr, 64'd10);
        chk("full_ready_after", lu_ready, 1'b1);
        cyc(1'b1, 5'd2, 64'h22, 1'b1, 5'd14, 64'h204, 5'd14);
        idle(6);

        // Starvation: one queued entry, pipeline busy long enough to trip the limit.
        cyc(1'b1, 5'd9, 64'h99, 1'b1, 5'd20, 64'h2020, 5'd0);
        for (int i = 0; i < STARVE_LIMIT + 1; i++)
            cyc(1'b1, 5'(1 + i), 64'(300 + i), 1'b0, '0, '0, 5'd20);
        chk("starve_stall_set", stall_req, 1'b1);
        cyc(1'b0, '0, '0, 1'b0, '0, '0, 5'd0);
        chk("starve_stall_clr", stall_req, 1'b0);
        chk("starve_drain_addr", rf_waddr, 64'd20);

        // x0: a pipeline write to x0 leaves the slot free; LU result for x0 is dropped.
        cyc(1'b1, 5'd4, 64'h44, 1'b1, 5'd21, 64'h2121, 5'd0);
        cyc(1'b1, 5'd0, 64'hDEAD, 1'b1, 5'd0, 64'hBEEF, 5'd0);
        chk("x0_drain_addr", rf_waddr, 64'd21);
        cyc(1'b0, '0, '0, 1'b0, '0, '0, 5'd0);
        chk("x0_discarded", rf_we, 1'b0);

        // Idle-path LU latency.
        cyc(1'b0, '0, '0, 1'b1, 5'd3, 64'h1234, 5'd3);
`ifdef WB_ARB_BYPASS_EN
        chk("bypass_we", rf_we, 1'b1);
        chk("bypass_data", rf_wdata, 64'h1234);
`else
        chk("nobypass_we", rf_we, 1'b0);
        query_rd = 5'd3;
        #1;
        chk("nobypass_pend", pend_hit, 1'b1);
`endif
        cyc(1'b0, '0, '0, 1'b0, '0, '0, 5'd3);
        idle(2);

        // Reset mid-stream with three queued results.
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 5'(5 + i), 64'(400 + i), 1'b1, 5'(24 + i), 64'(500 + i), 5'd25);
        wb_reg_write = 1'b0;
        lu_valid     = 1'b0;
        query_rd     = 5'd25;
        rst_n        = 1'b0;
        #1;
        chk("rst_rf_we", rf_we, 1'b0);
        chk("rst_rf_waddr", rf_waddr, 64'd0);
        chk("rst_rf_wdata", rf_wdata, 64'd0);
        chk("rst_stall", stall_req, 1'b0);
        chk("rst_lu_ready", lu_ready, 1'b1);
        chk("rst_pend_hit", pend_hit, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++)
            cyc($urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), {$urandom, $urandom},
                $urandom_range(0, 99) < 45, 5'($urandom_range(0, 7)), {$urandom, $urandom},
                5'($urandom_range(0, 7)));
        idle(DEPTH + 2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
